sram_1rw1r_ctrl: RTL

Parametrised behavioural successor to the team's 1RW+1R OpenRAM model, used for OpenTitan SoC scratch and instruction memories. It runs on one clock with synchronous, registered reads and configurable read latency (1 or 2). It adds byte-lane masking of any granularity, optional write-to-read bypass between ports, and a reset-triggered zero-initialisation FSM. It also adds explicit read-valid and ready/init-done status.

---
 rtl/sram_1rw1r_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_1rw1r_ctrl.sv
// rtl/sram_1rw1r_ctrl.sv - 1RW+1R SRAM controller with lane masks, bypass and zero-init
// Registered reads with 1 or 2 cycle latency; init FSM clears memory after reset.

module sram_1rw1r_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 1,
  parameter bit BYPASS       = 1'b1,
  parameter bit INIT_ZERO    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_csb,
  input  logic                  a_web,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_csb,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  ready
);

  localparam int                    LANE_W    = DATA_WIDTH / NUM_WMASKS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  init_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_rd, a_we, b_rd;
  logic                  a_in_range, b_in_range;
  logic [DATA_WIDTH-1:0] a_word, b_word;

  logic [DATA_WIDTH-1:0] a_s1_data, b_s1_data;
  logic                  a_s1_vld, b_s1_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT_ZERO ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Gate with reset so a held reset never scribbles word 0.
        init_we = rst_ni;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_IDLE: ready_d = 1'b1;
    endcase
  end

  assign ready = ready_q;

  assign a_in_range = {1'b0, a_addr} < DEPTH_EXT;
  assign b_in_range = {1'b0, b_addr} < DEPTH_EXT;
  assign a_rd       = ready_q & ~a_csb & a_web;
  assign a_we       = ready_q & ~a_csb & ~a_web & a_in_range;
  assign b_rd       = ready_q & ~b_csb;

  // Port B sees lane-merged write data only when the write really lands.
  always_comb begin
    a_word = a_in_range ? mem[a_addr] : '0;
    b_word = b_in_range ? mem[b_addr] : '0;
    for (int k = 0; k < NUM_WMASKS; k++) begin
      if (BYPASS && a_we && (a_addr == b_addr) && a_wmask[k]) begin
        b_word[k*LANE_W +: LANE_W] = a_wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem[cnt_q] <= '0;
    end else if (a_we) begin
      for (int k = 0; k < NUM_WMASKS; k++) begin
        if (a_wmask[k]) begin
          mem[a_addr][k*LANE_W +: LANE_W] <= a_wdata[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_s1_vld  <= 1'b0;
      b_s1_vld  <= 1'b0;
      a_s1_data <= '0;
      b_s1_data <= '0;
    end else begin
      a_s1_vld <= a_rd;
      b_s1_vld <= b_rd;
      if (a_rd) a_s1_data <= a_word;
      if (b_rd) b_s1_data <= b_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_rvalid <= 1'b0;
          b_rvalid <= 1'b0;
          a_rdata  <= '0;
          b_rdata  <= '0;
        end else begin
          a_rvalid <= a_s1_vld;
          b_rvalid <= b_s1_vld;
          if (a_s1_vld) a_rdata <= a_s1_data;
          if (b_s1_vld) b_rdata <= b_s1_data;
        end
      end
    end else begin : g_lat1
      assign a_rvalid = a_s1_vld;
      assign b_rvalid = b_s1_vld;
      assign a_rdata  = a_s1_data;
      assign b_rdata  = b_s1_data;
    end
  endgenerate

endmodule
